// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package add_arbiter_pkg;

  // Operand/result width of the shared adder.
  localparam int ADD_W = 32;

  // Edges from the one that samples start to the one that raises done.
  localparam int F_LAT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2,
    RESPOND   = 2'd3
  } state_t;

endpackage

// File: rtl/add_arbiter_f.sv
// Shared multi-cycle adder: captures a/b on start, presents a+b (mod 2^ADD_W) with done.
// Latency: done rises F_LAT edges after the edge that samples start.
// Backpressure: none; done is a level held until the next start (or reset) clears it.
module add_arbiter_f
  import add_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(F_LAT + 1);

  logic [CW-1:0]    cnt;
  logic [ADD_W-1:0] a_q;
  logic [ADD_W-1:0] b_q;

  // Capture operands on start, count down, then publish the sum and raise done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      done <= 1'b0;
      cnt  <= CW'(F_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        // Carry out is dropped: the sum wraps modulo 2^ADD_W.
        result <= a_q + b_q;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one shared adder.
// Latency: ack rises on the 5th rising edge counting the edge that samples req; next grant 2 edges after ack.
// Backpressure: requesters hold req (level) until ack; losers simply wait, nothing is dropped.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    result,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  state_t        state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;

  logic          f_start;
  logic          f_rst;
  logic [W-1:0]  f_a;
  logic [W-1:0]  f_b;
  logic [W-1:0]  f_result;
  logic          f_done;

  // Round-robin pick: first set req bit searching upward from last+1, wrapping.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Operands follow the registered grant for the whole operation.
  always_comb begin
    f_a = op_a[int'(gidx)*W +: W];
    f_b = op_b[int'(gidx)*W +: W];
  end

  // Adder reset tracks ours so a reset mid-operation discards any pending done.
  assign f_rst = ~reset;

  add_arbiter_f f (
    .clk    (clk),
    .reset  (f_rst),
    .start  (f_start),
    .a      (f_a),
    .b      (f_b),
    .result (f_result),
    .done   (f_done)
  );

  // Control FSM: grant, skip the stale done level, wait for the fresh one, respond.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ack     <= '0;
      busy    <= 1'b0;
      result  <= '0;
      f_start <= 1'b0;
      last    <= LAST_INIT;
      gidx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            gidx    <= pick;
            f_start <= 1'b1;
            busy    <= 1'b1;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          f_start <= 1'b0;
          // done may still be high from the previous operation; wait for it to drop.
          if (!f_done) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (f_done) begin
            result <= f_result;
            ack    <= NREQ'(1) << gidx;
            last   <= gidx;
            state  <= RESPOND;
          end
        end
        RESPOND: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: scoreboard of expected (requester, sum) per ack.
// Latency: checks ack on the 5th edge and grant spacing between back-to-back operations.
// Backpressure: requesters hold req until their ack, then drop it.
module tb_add_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic [3:0]   ack;
  logic [31:0]  result;
  logic         busy;

  typedef struct {
    int          idx;
    logic [31:0] res;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         ack_cnt = 0;
  int         cyc = 0;
  int         last_ack_cyc = 0;
  logic [3:0] last_ack = 4'b0;

  add_arbiter #(.NREQ(4), .W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .ack    (ack),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i*32 +: 32] = a;
    op_b[i*32 +: 32] = b;
  endtask

  task automatic push_exp(input int i, input logic [31:0] r);
    exp_t e;
    e.idx = i;
    e.res = r;
    sb_q.push_back(e);
  endtask

  // Observes every ack just after the edge and compares against the scoreboard head.
  task automatic monitor();
    exp_t       e;
    logic [3:0] exp_ack;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack !== 4'b0) begin
        ack_cnt++;
        last_ack     = ack;
        last_ack_cyc = cyc;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got ack=%b result=%h, expected no ack", ack, result);
        end else begin
          e = sb_q.pop_front();
          exp_ack = 4'b0001 << e.idx;
          if (ack !== exp_ack || result !== e.res) begin
            bad++;
            $display("FAIL ack_result: got ack=%b result=%h, expected ack=%b result=%h",
                     ack, result, exp_ack, e.res);
          end
        end
      end
    end
  endtask

  // Waits for n acks within a cycle budget, optionally dropping each acked req bit.
  task automatic run_acks(input int n, input bit drop_each, input int budget, output bit ok);
    int start;
    int prev;
    ok    = 1'b0;
    start = ack_cnt;
    prev  = ack_cnt;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack_cnt != prev) begin
        prev = ack_cnt;
        if (drop_each) req = req & ~last_ack;
      end
      if (ack_cnt - start >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int busy_seen;
    reset = 1'b0;
    req   = 4'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    total++;
    if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b, expected 0000", ack); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h, expected 0", result); end
    reset = 1'b1;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen != 0) begin bad++; $display("FAIL idle_no_req: busy cycles=%0d, expected 0", busy_seen); end
  endtask

  task automatic test_single();
    int first;
    int bc;
    int start;
    first = 0;
    bc    = 0;
    start = ack_cnt;
    set_ops(0, 32'd3, 32'd4);
    push_exp(0, 32'd7);
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (first == 0 && ack_cnt != start) begin
        first = c;
        req   = 4'b0;
      end
    end
    total++;
    if (first != 5) begin bad++; $display("FAIL single_latency: got %0d clocks, expected 5", first); end
    total++;
    if (bc != 5) begin bad++; $display("FAIL single_busy: got %0d cycles, expected 5", bc); end
    total++;
    if (result !== 32'd7) begin bad++; $display("FAIL single_hold: got %h, expected 7", result); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b, expected 0", busy); end
  endtask

  task automatic test_contention();
    bit ok;
    pulse_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd10);
    push_exp(0, 32'd10);
    push_exp(1, 32'd11);
    push_exp(2, 32'd12);
    push_exp(3, 32'd13);
    push_exp(0, 32'd10);
    req = 4'b1111;
    run_acks(5, 1'b0, 80, ok);
    req = 4'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL contention_timeout: acks=%0d, expected 5 more", ack_cnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    set_ops(1, 32'hFFFF_FFFF, 32'd1);
    push_exp(1, 32'd0);
    req = 4'b0010;
    run_acks(1, 1'b1, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout: no ack, expected ack=0010"); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL wrap_result: got %h, expected 0", result); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int seen;
    int prev;
    t1   = 0;
    t2   = 0;
    seen = 0;
    prev = ack_cnt;
    set_ops(2, 32'd5, 32'd5);
    push_exp(2, 32'd10);
    push_exp(2, 32'd12);
    req = 4'b0100;
    for (int c = 0; c < 40 && seen < 2; c++) begin
      @(negedge clk);
      if (ack_cnt != prev) begin
        prev = ack_cnt;
        seen++;
        if (seen == 1) begin
          t1 = last_ack_cyc;
          set_ops(2, 32'd6, 32'd6);
        end else begin
          t2  = last_ack_cyc;
          req = 4'b0;
        end
      end
    end
    req = 4'b0;
    total++;
    if (seen != 2) begin bad++; $display("FAIL b2b_count: got %0d acks, expected 2", seen); end
    total++;
    if (t2 - t1 != 6) begin bad++; $display("FAIL b2b_spacing: got %0d clocks, expected 6", t2 - t1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_ops(3, 32'd100, 32'd200);
    req = 4'b1000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 4'b0) begin bad++; $display("FAIL abort_ack: got %b, expected 0000", ack); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    reset = 1'b1;
    set_ops(0, 32'd1, 32'd2);
    push_exp(0, 32'd3);
    push_exp(3, 32'd300);
    req = 4'b1001;
    run_acks(2, 1'b1, 40, ok);
    req = 4'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL abort_recover: acks=%0d, expected 2 more", ack_cnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_late();
    bit ok;
    set_ops(2, 32'd7, 32'd1);
    push_exp(2, 32'd8);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    set_ops(0, 32'd20, 32'd22);
    push_exp(0, 32'd42);
    req[0] = 1'b1;
    run_acks(2, 1'b1, 40, ok);
    req = 4'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL late_timeout: acks=%0d, expected 2 more", ack_cnt); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0;
    op_a  = '0;
    op_b  = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_late();
    repeat (4) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
